// File: rtl/crypto_bus_pkg.sv
// ---------------------------------------------------------------------------
// crypto_bus_pkg
//   Shared definitions for the crypto subsystem data bus: requester count,
//   source id constants and the arbiter state encoding.
//   Source ids: ID_MEM=0 (memory), ID_SHA=1, ID_AES=2, ID_CTRL=3 (control).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package crypto_bus_pkg;

    localparam int NREQ = 4;

    localparam logic [1:0] ID_MEM  = 2'd0;
    localparam logic [1:0] ID_SHA  = 2'd1;
    localparam logic [1:0] ID_AES  = 2'd2;
    localparam logic [1:0] ID_CTRL = 2'd3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
//   Purely combinational round-robin search. Starting at last+1 (mod 4) and
//   moving upward, the first requester with its req bit set wins.
//   Ports:
//     req    [3:0] in   per-requester request
//     last   [1:0] in   previous winner (search starts just after it)
//     onehot [3:0] out  one-hot winner, zero when no request
//     id     [1:0] out  encoded winner, zero when no request
//     any          out  at least one request present
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module rr_priority_picker
    import crypto_bus_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic [NREQ-1:0] onehot,
    output logic [1:0]      id,
    output logic            any
);

    // Candidate order: w_cand[0] is the highest priority this cycle.
    logic [1:0] w_cand [NREQ];
    logic       w_found;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            // 2-bit add wraps naturally, giving the mod-4 rotation.
            assign w_cand[gi] = last + 2'(gi + 1);
        end
    endgenerate

    always_comb begin
        onehot  = '0;
        id      = 2'd0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[w_cand[k]]) begin
                w_found            = 1'b1;
                id                 = w_cand[k];
                onehot[w_cand[k]]  = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/data_bus_arbiter.sv
// ---------------------------------------------------------------------------
// data_bus_arbiter
//   Round-robin arbiter for a shared data bus with four requesters
//   (0 mem, 1 sha, 2 aes, 3 ctrl). A winner owns the bus until its last beat
//   completes or it drops req with no beat in flight; one IDLE cycle always
//   separates consecutive grants and an owner is never preempted.
//
//   Optional feature (macro DATA_BUS_TIMEOUT_EN): a grant that sees
//   TIMEOUT_CYCLES consecutive cycles without a completing beat is forcibly
//   released and timeout_err pulses for one cycle. Without the macro the
//   counter is absent, timeout_err is 0 and a grant is held indefinitely.
//
//   Parameters: DATAW (bus width), TIMEOUT_CYCLES (idle cycles before release)
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     req[3:0]              per-requester bus request
//     src_data[4*DATAW-1:0] packed requester data, slice i = requester i
//     src_valid/src_last    per-requester beat valid / last marker
//     src_ready[3:0]        per-requester beat accept (owner only)
//     bus_data/bus_valid    shared bus outputs (zero when idle)
//     bus_ready             destination accept
//     grant[3:0], grant_id  current owner (one-hot / encoded), zero when idle
//     busy                  grant held
//     timeout_err           one-cycle pulse on forced release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module data_bus_arbiter
    import crypto_bus_pkg::*;
#(
    parameter int DATAW          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DATAW-1:0] src_data,
    input  logic [NREQ-1:0]       src_valid,
    input  logic [NREQ-1:0]       src_last,
    output logic [NREQ-1:0]       src_ready,
    output logic [DATAW-1:0]      bus_data,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [NREQ-1:0]       grant,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic                  timeout_err
);

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
            $error("data_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    arb_state_t       r_state,       w_state_next;
    logic [1:0]       r_owner,       w_owner_next;
    logic [1:0]       r_last_winner, w_last_next;
    logic [NREQ-1:0]  r_grant,       w_grant_next;

    logic [NREQ-1:0]  w_pick_onehot;
    logic [1:0]       w_pick_id;
    logic             w_pick_any;

    logic [DATAW-1:0] w_src_slice [NREQ];
    logic             w_owned;
    logic             w_beat;
    logic             w_timeout_hit;
    logic             w_release;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_src_slice[gi] = src_data[gi*DATAW +: DATAW];
        end
    endgenerate

    rr_priority_picker u_picker (
        .req    (req),
        .last   (r_last_winner),
        .onehot (w_pick_onehot),
        .id     (w_pick_id),
        .any    (w_pick_any)
    );

    assign w_owned = (r_state == ARB_OWNED);
    assign w_beat  = bus_valid && bus_ready;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ARB_IDLE;
            r_owner       <= ID_MEM;
            r_grant       <= '0;
            // Search starts at last_winner+1, so requester 0 is first after reset.
            r_last_winner <= ID_CTRL;
        end else begin
            r_state       <= w_state_next;
            r_owner       <= w_owner_next;
            r_grant       <= w_grant_next;
            r_last_winner <= w_last_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_grant_next = r_grant;
        w_last_next  = r_last_winner;
        w_release    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // Leaving IDLE only from here guarantees the idle gap between grants.
                if (w_pick_any) begin
                    w_state_next = ARB_OWNED;
                    w_owner_next = w_pick_id;
                    w_grant_next = w_pick_onehot;
                end
            end
            ARB_OWNED: begin
                // A completing beat always wins over a same-cycle timeout.
                if (w_beat && src_last[r_owner]) begin
                    w_release = 1'b1;
                end else if (!w_beat && !req[r_owner]) begin
                    w_release = 1'b1;
                end else if (w_timeout_hit) begin
                    w_release = 1'b1;
                end
                if (w_release) begin
                    w_state_next = ARB_IDLE;
                    w_grant_next = '0;
                    w_last_next  = r_owner;
                end
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        bus_data  = '0;
        bus_valid = 1'b0;
        src_ready = '0;
        if (w_owned) begin
            bus_data           = w_src_slice[r_owner];
            bus_valid          = src_valid[r_owner];
            src_ready[r_owner] = bus_ready;
        end
    end

    assign grant    = r_grant;
    assign busy     = w_owned;
    assign grant_id = w_owned ? r_owner : 2'd0;

    // ---------------- optional grant timeout ----------------
`ifdef DATA_BUS_TIMEOUT_EN
    // Counter holds the number of beat-less owned cycles already seen;
    // the TIMEOUT_CYCLES-th such cycle triggers the release.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_idle_cnt;
    logic             r_timeout_err;

    // req must still be high: a dropped request is an ordinary release.
    assign w_timeout_hit = w_owned && !w_beat && req[r_owner] && (r_idle_cnt == CNT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout_hit;
            // Cleared throughout IDLE, so every grant starts from zero.
            if (!w_owned || w_beat) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + CNT_W'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
`timescale 1ns/1ps

module tb_data_bus_arbiter;
    import crypto_bus_pkg::*;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, src_valid, src_last, src_ready, grant;
    logic [31:0] src_data;
    logic [7:0]  bus_data;
    logic        bus_valid, bus_ready, busy, timeout_err;
    logic [1:0]  grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_bus_arbiter #(.DATAW(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .bus_data    (bus_data),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0; src_valid = 4'b0; src_last = 4'b0; bus_ready = 1'b0; src_data = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111; src_valid = 4'b1111; src_last = 4'b1111; bus_ready = 1'b1;
        src_data = 32'hA3A2A1A0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({grant, grant_id, busy, bus_valid, src_ready, bus_data, timeout_err} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_state got grant=%b id=%0d busy=%b valid=%b ready=%b data=%h terr=%b want all zero",
                     grant, grant_id, busy, bus_valid, src_ready, bus_data, timeout_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_first_priority got grant=%b want 0001", grant);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_owner();
        logic [7:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        do_reset();
        tick();
        req = 4'b0100; src_valid = 4'b0100; src_last = 4'b0; bus_ready = 1'b1;
        src_data = 32'h0; src_data[23:16] = beats[0];
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_latency got grant=%b want 0000", grant);
        end
        for (int b = 0; b < 3; b++) begin
            tick();
            src_data[23:16] = beats[b];
            src_last[2] = (b == 2);
            @(negedge clk);
            n_cmp++;
            if ({grant, grant_id, busy, bus_valid, src_ready, bus_data} !== {4'b0100, 2'd2, 1'b1, 1'b1, 4'b0100, beats[b]}) begin
                n_bad++;
                $display("FAIL single_beat%0d got grant=%b id=%0d busy=%b valid=%b ready=%b data=%h want 0100/2/1/1/0100/%h",
                         b, grant, grant_id, busy, bus_valid, src_ready, bus_data, beats[b]);
            end
        end
        tick();
        req = 4'b0; src_valid = 4'b0; src_last = 4'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, grant} !== 5'b0) begin
            n_bad++;
            $display("FAIL single_done got busy=%b grant=%b want 0/0000", busy, grant);
        end
        $display("test_single_owner done");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rr [10];
        exp_rr[0] = 4'b0000; exp_rr[1] = 4'b0001; exp_rr[2] = 4'b0000; exp_rr[3] = 4'b0010;
        exp_rr[4] = 4'b0000; exp_rr[5] = 4'b0100; exp_rr[6] = 4'b0000; exp_rr[7] = 4'b1000;
        exp_rr[8] = 4'b0000; exp_rr[9] = 4'b0001;
        do_reset();
        tick();
        req = 4'b1111; src_valid = 4'b1111; src_last = 4'b1111; bus_ready = 1'b1;
        src_data = 32'hA3A2A1A0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            n_cmp++;
            if ({grant, bus_valid} !== {exp_rr[k], |exp_rr[k]}) begin
                n_bad++;
                $display("FAIL rr_cycle%0d got grant=%b valid=%b want %b/%b", k, grant, bus_valid, exp_rr[k], |exp_rr[k]);
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_no_preempt();
        logic [3:0] exp_g [6];
        exp_g[0] = 4'b0000; exp_g[1] = 4'b0010; exp_g[2] = 4'b0010;
        exp_g[3] = 4'b0010; exp_g[4] = 4'b0000; exp_g[5] = 4'b0001;
        do_reset();
        tick();
        req = 4'b0010; src_valid = 4'b0010; src_last = 4'b0; bus_ready = 1'b1;
        src_data = 32'h00005500;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            if (k == 2) begin req[0] = 1'b1; src_valid[0] = 1'b1; end
            if (k == 3) src_last[1] = 1'b1;
            if (k == 4) begin req[1] = 1'b0; src_valid[1] = 1'b0; src_last = 4'b0; end
            @(negedge clk);
            n_cmp++;
            if (grant !== exp_g[k]) begin
                n_bad++;
                $display("FAIL preempt_cycle%0d got grant=%b want %b", k, grant, exp_g[k]);
            end
            if (k == 2 || k == 3) begin
                n_cmp++;
                if (src_ready[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL preempt_ready0 cycle%0d got src_ready=%b want bit0=0", k, src_ready);
                end
            end
        end
        req = 4'b0; src_valid = 4'b0;
        $display("test_no_preempt done");
    endtask

    task automatic test_owner_drop();
        logic [3:0] exp_g [6];
        exp_g[0] = 4'b0000; exp_g[1] = 4'b1000; exp_g[2] = 4'b1000;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0000; exp_g[5] = 4'b0001;
        do_reset();
        tick();
        req = 4'b1000; src_valid = 4'b0; src_last = 4'b0; bus_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            if (k == 3) req = 4'b0001;
            @(negedge clk);
            n_cmp++;
            if (grant !== exp_g[k]) begin
                n_bad++;
                $display("FAIL drop_cycle%0d got grant=%b want %b", k, grant, exp_g[k]);
            end
        end
        req = 4'b0;
        $display("test_owner_drop done");
    endtask

    task automatic test_reset_midtransfer();
        do_reset();
        tick();
        req = 4'b0010; src_valid = 4'b0010; src_last = 4'b0; bus_ready = 1'b1;
        src_data = 32'h00005500;
        @(negedge clk);
        tick();
        @(negedge clk);
        n_cmp++;
        if ({grant, bus_valid} !== 5'b0010_1) begin
            n_bad++;
            $display("FAIL midrst_pre got grant=%b valid=%b want 0010/1", grant, bus_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({grant, bus_valid, src_ready, busy} !== 10'b0) begin
            n_bad++;
            $display("FAIL midrst_async got grant=%b valid=%b ready=%b busy=%b want zeros", grant, bus_valid, src_ready, busy);
        end
        tick();
        n_cmp++;
        if ({src_ready, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL midrst_hold got ready=%b busy=%b want zeros", src_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1000; src_valid = 4'b1000; src_last = 4'b1000;
        tick();
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b1000) begin
            n_bad++;
            $display("FAIL midrst_regrant got grant=%b want 1000", grant);
        end
        tick();
        req = 4'b1111; src_valid = 4'b1111; src_last = 4'b1111;
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_gap got grant=%b want 0000", grant);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL midrst_restart got grant=%b want 0001", grant);
        end
        req = 4'b0; src_valid = 4'b0; src_last = 4'b0;
        $display("test_reset_midtransfer done");
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int busy_cnt = 0;
        bit seen = 1'b0;
        do_reset();
        tick();
        req = 4'b0100; src_valid = 4'b0100; src_last = 4'b0; bus_ready = 1'b0;
        @(negedge clk);
`ifdef DATA_BUS_TIMEOUT_EN
        for (int c = 0; c < 400; c++) begin
            tick();
            if (seen) begin req = 4'b0; src_valid = 4'b0; end
            @(negedge clk);
            if (busy && !seen) busy_cnt++;
            if (timeout_err) begin
                pulses++;
                if (!seen) begin
                    seen = 1'b1;
                    n_cmp++;
                    if (busy !== 1'b0) begin
                        n_bad++;
                        $display("FAIL timeout_busy got busy=%b want 0", busy);
                    end
                end
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL timeout_pulses got %0d want 1", pulses);
        end
        n_cmp++;
        if (busy_cnt != TO) begin
            n_bad++;
            $display("FAIL timeout_hold got %0d cycles want %0d", busy_cnt, TO);
        end
`else
        for (int c = 0; c < 1000; c++) begin
            tick();
            @(negedge clk);
            if (timeout_err) pulses++;
        end
        n_cmp++;
        if (grant !== 4'b0100) begin
            n_bad++;
            $display("FAIL hold_1000 got grant=%b want 0100", grant);
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL hold_noerr got %0d pulses want 0", pulses);
        end
`endif
        req = 4'b0; src_valid = 4'b0;
        $display("test_timeout done (seen=%0d)", seen);
    endtask

    task automatic test_random(input int ncyc);
        int         m_owner, m_last, m_idle, c;
        logic       m_err, ev, beat;
        logic [3:0] eg, er;
        logic [7:0] ed;
        do_reset();
        m_owner = -1; m_last = 3; m_idle = 0; m_err = 1'b0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            tick();
            req       = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            src_valid = 4'($urandom | $urandom);
            src_last  = 4'($urandom & $urandom);
            bus_ready = ($urandom_range(0, 3) != 0);
            src_data  = $urandom;
            @(negedge clk);
            eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
            ev = (m_owner < 0) ? 1'b0 : src_valid[m_owner];
            ed = (m_owner < 0) ? 8'h00 : src_data[m_owner*8 +: 8];
            er = (m_owner >= 0 && bus_ready) ? eg : 4'b0;
            n_cmp++;
            if ({grant, busy, bus_valid, src_ready, bus_data, timeout_err} !== {eg, m_owner >= 0, ev, er, ed, m_err}) begin
                n_bad++;
                $display("FAIL rnd_cyc%0d got grant=%b busy=%b valid=%b ready=%b data=%h terr=%b want %b/%b/%b/%b/%h/%b",
                         cyc, grant, busy, bus_valid, src_ready, bus_data, timeout_err,
                         eg, m_owner >= 0, ev, er, ed, m_err);
            end
            if (m_owner >= 0) begin
                n_cmp++;
                if (grant_id !== 2'(m_owner)) begin
                    n_bad++;
                    $display("FAIL rnd_id cyc%0d got %0d want %0d", cyc, grant_id, m_owner);
                end
            end
            // Advance the reference to the next rising edge.
            m_err = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last + k) % 4;
                    if (req[c]) begin
                        m_owner = c;
                        m_idle  = 0;
                        break;
                    end
                end
            end else begin
                beat = ev && bus_ready;
                if (beat && src_last[m_owner]) begin
                    m_last = m_owner; m_owner = -1;
                end else if (!beat && !req[m_owner]) begin
                    m_last = m_owner; m_owner = -1;
                end else if (beat) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
`ifdef DATA_BUS_TIMEOUT_EN
                    if (m_idle >= TO) begin
                        m_err = 1'b1; m_last = m_owner; m_owner = -1;
                    end
`endif
                end
            end
        end
        req = 4'b0; src_valid = 4'b0; src_last = 4'b0;
        $display("test_random done (%0d cycles)", ncyc);
    endtask

    initial begin
        test_reset();
        test_single_owner();
        test_round_robin();
        test_no_preempt();
        test_owner_drop();
        test_reset_midtransfer();
        test_timeout();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
